cursor_selector: RTL and testbench

Parametrised successor to the alarm-clock point selector. It moves an edit cursor across `N` display fields (digits or points) in both directions and wraps at a runtime field limit. It auto-repeats while a button is held and blinks the selected field. It sits between the debounced button logic and the display driver, which uses its one-hot mask to highlight or blank the field being edited.

---
 rtl/cursor_pkg.sv | 25 ++
 rtl/step_repeat.sv | 50 +++++
 rtl/cursor_selector.sv | 154 +++++++++++++++
 tb/tb_cursor_selector.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// Shared helpers for the edit-cursor selector: limit normalisation,
// index-to-one-hot decode and the step-direction encoding.
package cursor_pkg;

    // Widest field count the one-hot decode helper supports.
    localparam int MAX_FIELDS = 64;

    // Net direction of a cursor move in one cycle.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_INC  = 2'd1,
        DIR_DEC  = 2'd2
    } dir_e;

    // A zero or oversized limit means "use every physical field".
    function automatic int norm_limit(input int max_v, input int n);
        return (max_v == 0 || max_v > n) ? n : max_v;
    endfunction

    // Decode a field index into a one-hot mask; callers truncate to N bits.
    function automatic logic [MAX_FIELDS-1:0] idx_to_onehot(input int idx);
        return {{(MAX_FIELDS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/step_repeat.sv
// Button step generator: one step on a rising edge, then auto-repeat
// while held (first repeat after REPEAT_DELAY cycles, then every
// REPEAT_RATE cycles). Flush disarms repeating until a fresh press.
module step_repeat #(
    parameter int REPEAT_DELAY = 6,
    parameter int REPEAT_RATE  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_flush,
    input  logic i_btn,
    output logic o_step
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);

    logic          r_prev;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic          w_rise;
    logic          w_repeat;

    assign w_rise   = i_btn & ~r_prev;
    assign w_repeat = i_btn & r_prev & r_armed & (r_cnt == '0);
    assign o_step   = i_en & (w_rise | w_repeat);

    // Edge history always tracks the button; the countdown to the next
    // repeat is reloaded on every step and dropped on release/disable/flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_prev <= i_btn;
            if (!i_en || !i_btn || i_flush) begin
                r_armed <= 1'b0;
                r_cnt   <= '0;
            end else if (o_step) begin
                r_armed <= 1'b1;
                r_cnt   <= w_rise ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_RATE - 1);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cursor_selector.sv
// Edit cursor over N display fields: bidirectional stepping with
// auto-repeat, wrap at a runtime limit, clamp when the limit shrinks,
// and a blink phase that restarts whenever the selection changes.
module cursor_selector
    import cursor_pkg::*;
#(
    parameter int  N            = 8,
    parameter int  BLINK_HALF   = 4,
    parameter int  REPEAT_DELAY = 6,
    parameter int  REPEAT_RATE  = 3,
    localparam int W            = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         active,
    input  logic         inc,
    input  logic         dec,
    input  logic [W:0]   max,
    output logic [W-1:0] sel,
    output logic [N-1:0] onehot,
    output logic [N-1:0] blink_mask,
    output logic         wrap
);

    localparam int BW = $clog2(BLINK_HALF + 1);

    logic [W-1:0]  r_sel;
    logic          r_wrap;
    logic          r_phase;
    logic          r_active_d;
    logic [BW-1:0] r_bcnt;

    logic [W:0]    w_lim;
    logic [W:0]    w_lim_m1;
    logic          w_clamp;
    logic [W-1:0]  w_base;
    logic [W-1:0]  w_sel_next;
    logic          w_wrap_next;
    logic          w_inc_step;
    logic          w_dec_step;
    logic          w_flush;
    logic          w_restart;
    dir_e          w_dir;
    logic [N-1:0]  w_onehot;

    // Simultaneous steps cancel and also disarm both repeaters.
    assign w_flush = w_inc_step & w_dec_step;

    step_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_inc_rep (
        .clk     (clk),
        .reset   (reset),
        .i_en    (active),
        .i_flush (w_flush),
        .i_btn   (inc),
        .o_step  (w_inc_step)
    );

    step_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_dec_rep (
        .clk     (clk),
        .reset   (reset),
        .i_en    (active),
        .i_flush (w_flush),
        .i_btn   (dec),
        .o_step  (w_dec_step)
    );

    assign w_lim    = (W+1)'(norm_limit(int'(max), N));
    assign w_lim_m1 = w_lim - 1'b1;
    // A cursor beyond the limit is pulled back to 0 before any step applies.
    assign w_clamp  = ({1'b0, r_sel} >= w_lim);
    assign w_base   = w_clamp ? '0 : r_sel;

    // Resolve the two step pulses into a single net direction.
    always_comb begin
        w_dir = DIR_NONE;
        if (w_inc_step && !w_dec_step) begin
            w_dir = DIR_INC;
        end else if (w_dec_step && !w_inc_step) begin
            w_dir = DIR_DEC;
        end
    end

    // Next cursor value with wrap detection at either end of the range.
    always_comb begin
        w_sel_next  = w_base;
        w_wrap_next = 1'b0;
        case (w_dir)
            DIR_INC: begin
                if ({1'b0, w_base} == w_lim_m1) begin
                    w_sel_next  = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_sel_next = w_base + 1'b1;
                end
            end
            DIR_DEC: begin
                if (w_base == '0) begin
                    w_sel_next  = w_lim_m1[W-1:0];
                    w_wrap_next = 1'b1;
                end else begin
                    w_sel_next = w_base - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Any move, clamp or fresh activation shows the field immediately.
    assign w_restart = (w_dir != DIR_NONE) | w_clamp | (active & ~r_active_d);

    // Cursor register and its one-cycle wrap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_sel  <= w_sel_next;
            r_wrap <= w_wrap_next;
        end
    end

    // Blink half-period counter and phase, restarted on selection changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcnt     <= '0;
            r_phase    <= 1'b1;
            r_active_d <= 1'b0;
        end else begin
            r_active_d <= active;
            if (w_restart) begin
                r_bcnt  <= '0;
                r_phase <= 1'b1;
            end else if (r_bcnt == BW'(BLINK_HALF - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign w_onehot   = active ? N'(idx_to_onehot(int'(r_sel))) : '0;
    assign sel        = r_sel;
    assign wrap       = r_wrap;
    assign onehot     = w_onehot;
    assign blink_mask = r_phase ? w_onehot : '0;

endmodule

// File: tb/tb_cursor_selector.sv
// Self-checking bench for cursor_selector (N=8, BLINK_HALF=4,
// REPEAT_DELAY=6, REPEAT_RATE=3).
module tb_cursor_selector;

    logic       clk = 1'b0;
    logic       reset;
    logic       active;
    logic       inc;
    logic       dec;
    logic [3:0] mx;
    logic [2:0] sel;
    logic [7:0] onehot;
    logic [7:0] blink_mask;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       act;
        logic       inc;
        logic       dec;
        logic [3:0] mx;
        logic [2:0] sel;
        logic       wrap;
        logic       chk_blink;
        logic       phase;
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        logic       wrap;
        logic [7:0] onehot;
        logic       chk_blink;
        logic [7:0] blink;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    cursor_selector #(
        .N            (8),
        .BLINK_HALF   (4),
        .REPEAT_DELAY (6),
        .REPEAT_RATE  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .active     (active),
        .inc        (inc),
        .dec        (dec),
        .max        (mx),
        .sel        (sel),
        .onehot     (onehot),
        .blink_mask (blink_mask),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act_v, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic a, input logic i, input logic d, input logic [3:0] m,
                                input logic [2:0] s, input logic w, input logic cb, input logic p);
        vec_t v;
        v.act = a; v.inc = i; v.dec = d; v.mx = m;
        v.sel = s; v.wrap = w; v.chk_blink = cb; v.phase = p;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge outputs,
    // then compare against the DUT after the edge.
    task automatic apply(input logic a, input logic i, input logic d, input logic [3:0] m,
                         input logic [2:0] es, input logic ew, input logic cb, input logic ep);
        exp_t e;
        active = a; inc = i; dec = d; mx = m;
        e.sel       = es;
        e.wrap      = ew;
        e.onehot    = a ? (8'h01 << es) : 8'h00;
        e.chk_blink = cb;
        e.blink     = ep ? e.onehot : 8'h00;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sel", 32'(sel), 32'(e.sel));
        check("wrap", 32'(wrap), 32'(e.wrap));
        check("onehot", 32'(onehot), 32'(e.onehot));
        if (e.chk_blink) check("blink_mask", 32'(blink_mask), 32'(e.blink));
    endtask

    initial begin
        logic [2:0] hs;

        reset = 1'b1; active = 1'b1; inc = 1'b0; dec = 1'b0; mx = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_onehot", 32'(onehot), 32'h01);
        check("reset_blink", 32'(blink_mask), 32'h01);
        check("reset_wrap", 32'(wrap), 32'd0);
        reset = 1'b0;

        // Five single inc presses with limit 5, then one dec wrapping back.
        tbl.push_back(mk(1, 1, 0, 5, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 5, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 5, 2, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 5, 2, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 5, 3, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 5, 3, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 5, 4, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 5, 4, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 5, 0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 5, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 5, 4, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 5, 4, 0, 1, 1));
        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].act, tbl[k].inc, tbl[k].dec, tbl[k].mx,
                  tbl[k].sel, tbl[k].wrap, tbl[k].chk_blink, tbl[k].phase);
        end

        // Asynchronous reset acts without waiting for a clock edge.
        reset = 1'b1;
        #1;
        check("async_reset_sel", 32'(sel), 32'd0);
        check("async_reset_blink", 32'(blink_mask), 32'h01);
        #1;
        reset = 1'b0;

        // Held inc: steps at t0, t0+6, t0+9, t0+12.
        hs = 3'd0;
        for (int k = 0; k < 15; k++) begin
            if (k == 0 || (k >= 6 && (k - 6) % 3 == 0)) hs = hs + 3'd1;
            apply(1, 1, 0, 8, hs, 0, 0, 1);
        end
        apply(1, 0, 0, 8, 4, 0, 0, 1);

        // Both buttons together: cancel, and no repeats while both held.
        for (int k = 0; k < 13; k++) apply(1, 1, 1, 8, 4, 0, 0, 1);
        apply(1, 0, 0, 8, 4, 0, 0, 1);

        // Move to 6, then shrink limit to 4: clamp to 0 and blink restarts.
        apply(1, 1, 0, 8, 5, 0, 1, 1);
        apply(1, 0, 0, 8, 5, 0, 1, 1);
        apply(1, 1, 0, 8, 6, 0, 1, 1);
        apply(1, 0, 0, 8, 6, 0, 1, 1);
        apply(1, 0, 0, 4, 0, 0, 1, 1);
        for (int k = 0; k < 7; k++) apply(1, 0, 0, 4, 0, 0, 1, (k < 3));

        // Clamp and dec step in the same cycle: step taken from 0, wraps to L-1.
        apply(1, 1, 0, 8, 1, 0, 1, 1);
        apply(1, 0, 0, 8, 1, 0, 1, 1);
        apply(1, 1, 0, 8, 2, 0, 1, 1);
        apply(1, 0, 0, 8, 2, 0, 1, 1);
        apply(1, 1, 0, 8, 3, 0, 1, 1);
        apply(1, 0, 0, 8, 3, 0, 1, 1);
        apply(1, 0, 1, 2, 1, 1, 1, 1);
        apply(1, 0, 0, 2, 1, 0, 1, 1);

        // max=0 and max>N both mean all 8 fields.
        apply(1, 0, 1, 0, 0, 0, 1, 1);
        apply(1, 0, 0, 0, 0, 0, 1, 1);
        apply(1, 0, 1, 0, 7, 1, 1, 1);
        apply(1, 0, 0, 0, 7, 0, 1, 1);
        apply(1, 1, 0, 15, 0, 1, 1, 1);
        apply(1, 0, 0, 15, 0, 0, 1, 1);

        // Inactive: presses ignored, masks dark.
        apply(0, 1, 0, 15, 0, 0, 1, 1);
        apply(0, 0, 0, 15, 0, 0, 1, 1);
        apply(0, 1, 0, 15, 0, 0, 1, 1);
        apply(0, 0, 0, 15, 0, 0, 1, 1);

        // Reactivation: visible 4 cycles, dark 4, visible again.
        for (int k = 0; k < 12; k++) apply(1, 0, 0, 15, 0, 0, 1, (k < 4) || (k >= 8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
